// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped register window in front of a byte UART.
// The CPU reaches it through execute-stage load/store decode. Read data is
// registered for the memory stage. RX and TX FIFOs sit between the CPU side
// and the UART's valid/ready byte interface.
module uart_mmio_ctrl #(
    parameter int         DEPTH   = 8,
    parameter logic [3:0] BASE_HI = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [5:0]  opcode_e,
    input  logic [31:0] addr_e,
    input  logic [7:0]  wdata_e,
    output logic [31:0] rdata_m,
    output logic        sel_m,
    output logic [7:0]  DataIn,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  DataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady,
    output logic        rx_irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [7:0] OFF_TXST = 8'h00;
    localparam logic [7:0] OFF_RXST = 8'h04;
    localparam logic [7:0] OFF_TXD  = 8'h08;
    localparam logic [7:0] OFF_RXD  = 8'h0C;
    localparam logic [7:0] OFF_RXC  = 8'h10;
    localparam logic [7:0] OFF_TXC  = 8'h14;
    localparam logic [7:0] OFF_FLG  = 8'h18;

    // Occupancy step: simultaneous push and pop leave the count unchanged.
    function automatic logic [CW-1:0] f_next_cnt(input logic [CW-1:0] cnt,
                                                 input logic push,
                                                 input logic pop);
        case ({push, pop})
            2'b10:   return cnt + CW'(1);
            2'b01:   return cnt - CW'(1);
            default: return cnt;
        endcase
    endfunction

    // FIFO storage (data only, never reset) and control state
    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [PW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CW-1:0] r_tx_cnt, r_rx_cnt;
    logic [1:0]    r_flags;          // bit0 tx_ovf, bit1 rx_underflow
    logic [31:0]   r_rdata;
    logic          r_sel;

    logic          w_is_load, w_is_store, w_sel, w_hit_ld, w_hit_st;
    logic [7:0]    w_off;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic          w_tx_ovf_set, w_rx_unf_set, w_flags_clr;
    logic [31:0]   w_rd_val;
    logic          w_unused_addr;

    // Opcode classification: which opcodes count as loads and stores
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        case (opcode_e)
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: w_is_load  = 1'b1;
            6'h28, 6'h29, 6'h2B:               w_is_store = 1'b1;
            default: ;
        endcase
    end

    // Address bits between the block select and the register offset are don't-care.
    assign w_unused_addr = ^addr_e[27:8];

    assign w_off    = addr_e[7:0];
    assign w_sel    = (addr_e[31:28] == BASE_HI) && !stall;
    assign w_hit_ld = w_sel && w_is_load;
    assign w_hit_st = w_sel && w_is_store;

    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);

    // UART-facing handshakes are forced idle while reset is held, so a reset
    // in the middle of a transfer never completes a TX or RX handshake.
    assign DataInValid  = !w_tx_empty && !rst;
    assign DataIn       = r_tx_mem[r_tx_rp];
    assign DataOutReady = !w_rx_full && !rst;
    assign rx_irq       = !w_rx_empty && !rst;

    // Fullness/emptiness is judged on start-of-cycle counts, so a TX store to
    // a full FIFO drops even if the UART pops in the same cycle.
    assign w_tx_push    = w_hit_st && (w_off == OFF_TXD) && !w_tx_full;
    assign w_tx_ovf_set = w_hit_st && (w_off == OFF_TXD) &&  w_tx_full;
    assign w_tx_pop     = DataInValid && DataInReady;
    assign w_rx_push    = DataOutValid && DataOutReady;
    assign w_rx_pop     = w_hit_ld && (w_off == OFF_RXD) && !w_rx_empty;
    assign w_rx_unf_set = w_hit_ld && (w_off == OFF_RXD) &&  w_rx_empty;
    assign w_flags_clr  = w_hit_st && (w_off == OFF_FLG);

    // Register read mux; every value reflects state before this cycle's updates.
    always_comb begin
        w_rd_val = 32'h0;
        case (w_off)
            OFF_TXST: w_rd_val = {31'h0, !w_tx_full};
            OFF_RXST: w_rd_val = {31'h0, !w_rx_empty};
            OFF_RXD:  w_rd_val = w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rp]};
            OFF_RXC:  w_rd_val = {{(32-CW){1'b0}}, r_rx_cnt};
            OFF_TXC:  w_rd_val = {{(32-CW){1'b0}}, r_tx_cnt};
            OFF_FLG:  w_rd_val = {30'h0, r_flags};
            default:  w_rd_val = 32'h0;
        endcase
    end

    // FIFO data writes; stale entries are harmless because pointers gate them.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata_e;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= DataOut;
    end

    // FIFO pointers and counts; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
            r_tx_cnt <= f_next_cnt(r_tx_cnt, w_tx_push, w_tx_pop);
            r_rx_cnt <= f_next_cnt(r_rx_cnt, w_rx_push, w_rx_pop);
        end
    end

    // Sticky error flags; a store to the flag register clears both.
    always_ff @(posedge clk) begin
        if (rst)              r_flags <= 2'b00;
        else if (w_flags_clr) r_flags <= 2'b00;
        else                  r_flags <= r_flags | {w_rx_unf_set, w_tx_ovf_set};
    end

    // Memory-stage read register; frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
            r_sel   <= 1'b0;
        end else if (!stall) begin
            r_sel   <= w_hit_ld;
            r_rdata <= w_hit_ld ? w_rd_val : 32'h0;
        end
    end

    assign rdata_m = r_rdata;
    assign sel_m   = r_sel;

endmodule

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, meaning entries per FIFO (RX and TX); SHALL be a power of two, >= 2.
REQ-002 Parameter BASE_HI, default 4'h8, meaning address bits [31:28] that select this block.
REQ-003 Ports: clk, in, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Ports: rst, in, 1, reset; it SHALL be synchronous and active-high.
REQ-005 Ports: stall, in, 1, pipeline stall; when high, no CPU-side access SHALL take effect.
REQ-006 Ports: opcode_e, in, 6, execute-stage opcode.
REQ-007 Ports: addr_e, in, 32, execute-stage ALU address.
REQ-008 Ports: wdata_e, in, 8, store data, low byte.
REQ-009 Ports: rdata_m, out, 32, registered read data for the memory stage.
REQ-010 Ports: sel_m, out, 1, registered flag, high when the M-stage load targeted this block.
REQ-011 Ports: DataIn, out, 8, TX byte to the UART.
REQ-012 Ports: DataInValid, out, 1, TX byte valid.
REQ-013 Ports: DataInReady, in, 1, UART accepts the TX byte.
REQ-014 Ports: DataOut, in, 8, RX byte from the UART.
REQ-015 Ports: DataOutValid, in, 1, RX byte valid.
REQ-016 Ports: DataOutReady, out, 1, block accepts the RX byte.
REQ-017 Ports: rx_irq, out, 1, high when the RX FIFO is non-empty.

Function
REQ-018 The block SHALL be hit when addr_e[31:28]==BASE_HI; an access is a hit with stall low and opcode_e a load (0x20,0x21,0x23,0x24,0x25) or a store (0x28,0x29,0x2B).
REQ-019 Register map (addr_e[7:0]) SHALL be:
- 0x00: TX status, bit0 = TX not full (RO).
- 0x04: RX status, bit0 = RX not empty (RO).
- 0x08: TX data (WO).
- 0x0C: RX data (RO, pops).
- 0x10: RX count (RO).
- 0x14: TX count (RO).
- 0x18: sticky flags, bit0 = tx_ovf, bit1 = rx_underflow; any store clears both.
REQ-020 Unmapped offsets SHALL read 0 and ignore writes.
REQ-021 A hit load SHALL present its zero-extended value on rdata_m and assert sel_m exactly one cycle later (latency 1).
REQ-022 While stall is high, rdata_m and sel_m SHALL hold their values.
REQ-023 A hit non-load SHALL drive sel_m to 0 on the next edge.
REQ-024 A store to 0x08 with the TX FIFO not full SHALL push wdata_e.
REQ-025 A store to 0x08 with the TX FIFO full SHALL drop the byte and set tx_ovf; fullness is judged on the count at the start of the cycle, regardless of a same-cycle UART pop.
REQ-026 A load from 0x0C with RX non-empty SHALL return the head byte and pop it.
REQ-027 A load from 0x0C with RX empty SHALL return 0, not pop, and set rx_underflow.
REQ-028 DataInValid SHALL equal TX non-empty, and DataIn SHALL equal the TX head.
REQ-029 A TX pop SHALL occur on DataInValid && DataInReady.
REQ-030 DataOutReady SHALL equal !rx_full && !rst.
REQ-031 An RX push SHALL occur on DataOutValid && DataOutReady.
REQ-032 A same-cycle push and pop on one FIFO SHALL leave its count unchanged; data order SHALL be preserved.
REQ-033 Pointers SHALL wrap modulo DEPTH; counts are $clog2(DEPTH)+1 bits and range 0..DEPTH.
REQ-034 A read of a count register in the same cycle as a push or pop SHALL return the pre-update count.
REQ-035 A read of the flags in the same cycle as a flag-setting event SHALL return the old flags; the new flag is visible the next cycle.

Reset
REQ-036 On rst high at a clock edge: both FIFOs empty, both counts 0, pointers 0, flags 0, rdata_m 0, sel_m 0.
REQ-037 While rst is high, DataInValid, DataOutReady and rx_irq SHALL be 0.
REQ-038 Reset mid-transfer SHALL discard all FIFO contents without emitting a partial TX handshake.

Verification
REQ-039 Scenario: push 0x41,0x42 on RX via DataOutValid, then LW 0x8000000C twice -> rdata_m 0x41 then 0x42, each one cycle after the access; RX count 0; rx_irq low.
REQ-040 Scenario: DEPTH=8, 9 stores to 0x80000008 with DataInReady=0 -> TX count 8, ninth byte dropped, flags read 0x1; after one store to 0x18, flags read 0.
REQ-041 Scenario: hold DataOutValid high for 10 cycles with no CPU reads, DEPTH=8 -> DataOutReady falls after 8 accepts; RX count 8; the data order is intact on readback.
REQ-042 Scenario: LW 0x8000000C with RX empty -> rdata_m 0, flags bit1 set, RX pointers unchanged.
REQ-043 Scenario: TX count 3 and the CPU stores while the UART pops in the same cycle -> TX count stays 3; bytes emerge in FIFO order.
REQ-044 Scenario: assert rst with both FIFOs half full -> next cycle both counts 0, DataInValid 0, rdata_m 0, sel_m 0.
